// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs 32-bit words into 512-bit blocks with FIPS 180-4 padding and length.
// Optional build macro SHA1_PAD_BYTESWAP_EN byte-swaps in_data on entry (little-endian sources).
module sha1_msg_padder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic [511:0] block,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_first,
  output logic         block_last
);

  typedef enum logic [2:0] {
    ST_ACCEPT,
    ST_PAD80,
    ST_ZERO,
    ST_LEN,
    ST_EMIT
  } state_t;

  state_t       state, state_nx;
  logic [31:0]  word_buf [16];
  logic [3:0]   widx, widx_nx;
  logic [63:0]  len, len_nx;
  logic         first, first_nx;
  logic         pad80_pending, pad80_nx;
  logic         last_flag, last_nx;
  logic         msg_closed, closed_nx;

  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [31:0]  wr_data;
  logic         len_wr;
  logic [31:0]  word_in;
  logic [2:0]   n_bytes;

`ifdef SHA1_PAD_BYTESWAP_EN
  assign word_in = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign word_in = in_data;
`endif

  assign n_bytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;

  // Keep the first n bytes, drop the 0x80 marker right after them, zero the rest.
  function automatic logic [31:0] pad_last(input logic [31:0] d, input logic [2:0] n);
    logic [31:0] r;
    case (n)
      3'd0:    r = 32'h8000_0000;
      3'd1:    r = {d[31:24], 24'h80_0000};
      3'd2:    r = {d[31:16], 16'h8000};
      3'd3:    r = {d[31:8], 8'h80};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_ACCEPT;
      widx          <= 4'd0;
      len           <= 64'd0;
      first         <= 1'b1;
      pad80_pending <= 1'b0;
      last_flag     <= 1'b0;
      msg_closed    <= 1'b0;
    end else begin
      state         <= state_nx;
      widx          <= widx_nx;
      len           <= len_nx;
      first         <= first_nx;
      pad80_pending <= pad80_nx;
      last_flag     <= last_nx;
      msg_closed    <= closed_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) word_buf[i] <= 32'd0;
    end else begin
      if (wr_en) word_buf[wr_idx] <= wr_data;
      if (len_wr) begin
        word_buf[14] <= len[63:32];
        word_buf[15] <= len[31:0];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    widx_nx   = widx;
    len_nx    = len;
    first_nx  = first;
    pad80_nx  = pad80_pending;
    last_nx   = last_flag;
    closed_nx = msg_closed;
    wr_en     = 1'b0;
    wr_idx    = widx;
    wr_data   = 32'd0;
    len_wr    = 1'b0;

    case (state)
      ST_ACCEPT: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          widx_nx = widx + 4'd1;
          if (!in_last) begin
            wr_data = word_in;
            len_nx  = len + 64'd32;
            if (widx == 4'd15) state_nx = ST_EMIT;
          end else begin
            wr_data   = pad_last(word_in, n_bytes);
            len_nx    = len + {58'd0, n_bytes, 3'b000};
            closed_nx = 1'b1;
            if (n_bytes == 3'd4) pad80_nx = 1'b1;
            if (widx == 4'd15)          state_nx = ST_EMIT;
            else if (n_bytes == 3'd4)   state_nx = ST_PAD80;
            else if (widx == 4'd13)     state_nx = ST_LEN;
            else                        state_nx = ST_ZERO;
          end
        end
      end

      ST_PAD80: begin
        wr_en    = 1'b1;
        wr_data  = 32'h8000_0000;
        pad80_nx = 1'b0;
        widx_nx  = widx + 4'd1;
        if (widx == 4'd15)      state_nx = ST_EMIT;
        else if (widx == 4'd13) state_nx = ST_LEN;
        else                    state_nx = ST_ZERO;
      end

      // A fill that starts at word 15 cannot hold the length, so it just closes the block.
      ST_ZERO: begin
        wr_en   = 1'b1;
        wr_data = 32'd0;
        widx_nx = widx + 4'd1;
        if (widx == 4'd15)      state_nx = ST_EMIT;
        else if (widx == 4'd13) state_nx = ST_LEN;
      end

      ST_LEN: begin
        len_wr   = 1'b1;
        last_nx  = 1'b1;
        state_nx = ST_EMIT;
      end

      ST_EMIT: begin
        if (block_ready) begin
          widx_nx  = 4'd0;
          first_nx = 1'b0;
          if (last_flag) begin
            len_nx    = 64'd0;
            first_nx  = 1'b1;
            last_nx   = 1'b0;
            closed_nx = 1'b0;
            state_nx  = ST_ACCEPT;
          end else if (!msg_closed) begin
            state_nx = ST_ACCEPT;
          end else if (pad80_pending) begin
            state_nx = ST_PAD80;
          end else begin
            state_nx = ST_ZERO;
          end
        end
      end

      default: state_nx = ST_ACCEPT;
    endcase
  end

  assign in_ready    = (state == ST_ACCEPT) && reset_n;
  assign block_valid = (state == ST_EMIT);
  assign block_first = first && block_valid;
  assign block_last  = last_flag && block_valid;

  always_comb begin
    block = '0;
    for (int i = 0; i < 16; i++) block[511-32*i -: 32] = word_buf[i];
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Randomized bench for sha1_msg_padder against a byte-level FIPS 180-4 padding model.
module tb_sha1_msg_padder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic [511:0] block;
  logic         block_valid;
  logic         block_ready;
  logic         block_first;
  logic         block_last;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  blk_t        exp_q[$];
  blk_t        last_model[$];
  logic [31:0] msg_w[$];
  logic [2:0]  msg_n;
  int          total = 0;
  int          bad = 0;
  int          ready_mode = 0;

  sha1_msg_padder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .block       (block),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_first (block_first),
    .block_last  (block_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, actual, expected);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] to_bus(input logic [31:0] w);
`ifdef SHA1_PAD_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Reference: message as bytes, append 0x80, zero to 56 mod 64, append 64-bit bit length.
  task automatic model_push();
    logic [7:0]  bq[$];
    logic [63:0] bitlen;
    logic [31:0] w;
    blk_t        b;
    int          eff_n;
    int          nblk;
    eff_n = (msg_n > 3'd4) ? 4 : int'(msg_n);
    for (int i = 0; i < msg_w.size() - 1; i++) begin
      w = msg_w[i];
      for (int j = 0; j < 4; j++) bq.push_back(w[31-8*j -: 8]);
    end
    w = msg_w[msg_w.size()-1];
    for (int j = 0; j < eff_n; j++) bq.push_back(w[31-8*j -: 8]);
    bitlen = 64'(bq.size()) * 64'd8;
    bq.push_back(8'h80);
    while ((bq.size() % 64) != 56) bq.push_back(8'h00);
    for (int j = 7; j >= 0; j--) bq.push_back(bitlen[8*j+7 -: 8]);
    nblk = bq.size() / 64;
    last_model.delete();
    for (int k = 0; k < nblk; k++) begin
      b.data = '0;
      for (int j = 0; j < 64; j++) b.data = {b.data[503:0], bq[k*64+j]};
      b.first = (k == 0);
      b.last  = (k == nblk - 1);
      last_model.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic applyStimulus(input int gap);
    int  guard;
    bit  done;
    model_push();
    for (int i = 0; i < msg_w.size(); i++) begin
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        @(negedge clk);
        if ($urandom_range(99) < gap) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = to_bus(msg_w[i]);
          in_last  = (i == msg_w.size() - 1);
          in_bytes = in_last ? msg_n : 3'($urandom_range(7));
        end
        if (in_valid && in_ready) done = 1'b1;
        guard++;
        if (guard > 3000) begin
          total++;
          bad++;
          $display("[TB] FAIL input accept timeout: word %0d never accepted", i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || block_valid) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    checkFlag("drain within budget", c < 3000, 1'b1);
  endtask

  task automatic check_reset_values();
    checkFlag("reset in_ready", in_ready, 1'b0);
    checkFlag("reset block_valid", block_valid, 1'b0);
    checkFlag("reset block_first", block_first, 1'b0);
    checkFlag("reset block_last", block_last, 1'b0);
    checkOutput("reset block", block, 512'd0);
  endtask

  // Per-cycle scoreboard compare and block_ready driver.
  initial begin
    block_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && block_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected block: got %h want none", block);
        end else begin
          checkOutput("block data", block, exp_q[0].data);
          checkFlag("block_first", block_first, exp_q[0].first);
          checkFlag("block_last", block_last, exp_q[0].last);
        end
      end
      block_ready = (ready_mode == 1) ? 1'b0 : ($urandom_range(99) < 70);
      if (reset_n && block_valid && block_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [511:0] held;
    logic [511:0] cat;
    int           cnt;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
    #3;
    check_reset_values();
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    #1 checkFlag("in_ready after release", in_ready, 1'b1);

    $display("[TB] abc message");
    msg_w = '{32'h61626300};
    msg_n = 3'd3;
    applyStimulus(0);
    checkInt("abc block count", last_model.size(), 1);
    checkOutput("abc model", last_model[0].data, {32'h61626380, 448'h0, 32'h00000018});
    checkFlag("abc model first", last_model[0].first, 1'b1);
    checkFlag("abc model last", last_model[0].last, 1'b1);
    wait_drain();

    $display("[TB] empty message");
    msg_w = '{32'hDEADBEEF};
    msg_n = 3'd0;
    applyStimulus(0);
    cnt = 0;
    while (!block_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkInt("empty latency", cnt, 14);
    checkOutput("empty model", last_model[0].data, {32'h80000000, 480'h0});
    wait_drain();

    $display("[TB] 56-byte message");
    msg_w.delete();
    for (int i = 0; i < 14; i++) msg_w.push_back($urandom);
    msg_n = 3'd4;
    applyStimulus(20);
    checkInt("56B block count", last_model.size(), 2);
    checkOutput("56B block1 tail", {448'h0, last_model[0].data[63:0]}, {448'h0, 32'h80000000, 32'h0});
    checkFlag("56B block1 last", last_model[0].last, 1'b0);
    checkOutput("56B block2", last_model[1].data, {480'h0, 32'h000001C0});
    checkFlag("56B block2 first", last_model[1].first, 1'b0);
    wait_drain();

    $display("[TB] 64-byte message");
    msg_w.delete();
    cat = '0;
    for (int i = 0; i < 16; i++) begin
      msg_w.push_back($urandom);
      cat = {cat[479:0], msg_w[i]};
    end
    msg_n = 3'd6;
    applyStimulus(20);
    checkInt("64B block count", last_model.size(), 2);
    checkOutput("64B block1", last_model[0].data, cat);
    checkOutput("64B block2", last_model[1].data, {32'h80000000, 448'h0, 32'h00000200});
    wait_drain();

    $display("[TB] back-pressure hold");
    ready_mode = 1;
    msg_w = '{32'h61626300};
    msg_n = 3'd3;
    applyStimulus(0);
    cnt = 0;
    while (!block_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkFlag("hold block arrives", block_valid, 1'b1);
    held = block;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("hold block stable", block, held);
      checkFlag("hold in_ready low", in_ready, 1'b0);
      checkFlag("hold block_valid", block_valid, 1'b1);
    end
    ready_mode = 0;
    wait_drain();

    $display("[TB] reset mid-fill");
    msg_w = '{32'h41424344};
    msg_n = 3'd2;
    applyStimulus(0);
    repeat (4) @(negedge clk);
    #1 reset_n = 1'b0;
    exp_q.delete();
    #1 check_reset_values();
    @(negedge clk);
    #1 reset_n = 1'b1;
    #1 checkFlag("in_ready after abort", in_ready, 1'b1);
    msg_w = '{32'h61626300};
    msg_n = 3'd3;
    applyStimulus(0);
    wait_drain();

    $display("[TB] random messages");
    for (int m = 0; m < 40; m++) begin
      int nw;
      nw = ($urandom_range(3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 40);
      msg_w.delete();
      for (int i = 0; i < nw; i++) msg_w.push_back($urandom);
      msg_n = 3'($urandom_range(7));
      applyStimulus(30);
    end
    wait_drain();
    checkInt("scoreboard empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha1_msg_padder.md
# sha1_msg_padder

Upstream feeder for the SHA-1 core inside the user project. It accepts a message as a stream of 32-bit words, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and presents complete 512-bit blocks to the core. Each block carries first/last flags so the core can select init versus next.

## Interface
- No parameters; widths fixed by SHA-1.
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: padder can accept a word this cycle.
- `in_data` in 32: message word, big-endian (byte 0 in bits 31:24).
- `in_last` in 1: this word ends the message.
- `in_bytes` in 3: valid bytes in the last word, 0..4; values 5..7 are treated as 4; ignored when `in_last`=0.
- `block` out 512: padded block, word 0 in bits 511:480.
- `block_valid` out 1: `block` is complete and stable.
- `block_ready` in 1: core takes the block.
- `block_first` out 1: block is the first of its message.
- `block_last` out 1: block holds the length field.

## Operation
- Registers:
  - 16×32 word buffer.
  - `widx[3:0]` word index.
  - `len[63:0]` bit count, wraps mod 2^64.
  - `first` flag, set at start of each message.
  - `pad80_pending` flag.
  - state.
- States:
  - **ACCEPT**: `in_ready`=1.
    - Accepted non-last word: buf[widx]=data; len+=32; widx++. If widx was 15 → EMIT.
    - Accepted last word with n bytes: buf[widx] = data with bytes ≥n zeroed, 0x80 placed at byte n when n<4; len+=8n.
      - n=4: set `pad80_pending`.
      - Next state by the index the word was written at, called widx_old:
        - widx_old=15 → EMIT.
        - else if n=4 → PAD80.
        - else if widx_old+1 ≤ 14 → ZERO, or LEN if widx_old+1 = 14.
        - else → ZERO (zero fill to 16, no length).
  - **PAD80**: buf[widx]=0x80000000; clear `pad80_pending`; widx++.
    - If widx was 15 → EMIT.
    - Else → LEN if new widx = 14, ZERO otherwise.
  - **ZERO**: buf[widx]=0; widx++.
    - Stop at widx=14 → LEN when the length fits this block.
    - Otherwise continue to widx=16 (wraps to 0) → EMIT with `block_last`=0.
  - **LEN**: buf[14]=len[63:32], buf[15]=len[31:0] in one cycle; set `block_last` → EMIT.
  - **EMIT**: `block_valid`=1; `in_ready`=0. On `block_valid`&&`block_ready`: widx=0, `first` cleared, then:
    - `block_last` → clear len, set `first`, clear `block_last` → ACCEPT.
    - else if message still open (no last word yet) → ACCEPT.
    - else if `pad80_pending` → PAD80.
    - else → ZERO.
- `block_first` = `first` while in EMIT.

## Timing
- Reset values: `in_ready`=0 while `reset_n` low, 1 in the first cycle after release. `block_valid`=0, `block_first`=0, `block_last`=0, `block`=0, len=0, widx=0, state ACCEPT.
- At most one input word per clock; one fill/pad word per clock; the length field is written in a single clock.
- Latencies:
  - 16th non-last word accepted on edge k → `block_valid` high after edge k.
  - Empty message (`in_last`, `in_bytes`=0) accepted on edge 0 → words 1..13 zeroed on edges 1..13, length on edge 14, `block_valid` after edge 14.
- `block` and flags stay stable from `block_valid` rising until the handshake. `block_valid` drops the cycle after the handshake.
- Asserting `reset_n` mid-message or mid-EMIT aborts immediately; partial block and length are discarded.
- `in_valid` is ignored outside ACCEPT; the source must hold the word.

## Configuration
- `SHA1_PAD_BYTESWAP_EN`:
  - Defined: `in_data` is byte-swapped on entry, for little-endian CPU words. Byte count n then refers to the swapped order.
  - Undefined: `in_data` is used as-is, big-endian.

## Test plan
- "abc": one word 0x61626300, `in_last`, `in_bytes`=3 → single block.
  - word0=0x61626380, words1..14=0, word15=0x00000018.
  - `block_first`=`block_last`=1.
- Empty message: `in_bytes`=0 → word0=0x80000000, word15=0; `block_valid` exactly 14 clocks after accept.
- 14 full words (56 bytes), last `in_bytes`=4 → block 1 has word14=0x80000000, word15=0, first=1, last=0. Block 2 has words 0..13=0, word14=0, word15=0x000001C0, first=0, last=1.
- 64-byte message: block 1 is all data (first=1, last=0). Block 2 has word0=0x80000000, word15=0x00000200, last=1.
- Hold `block_ready`=0 for 20 cycles → `block` stable and `in_ready`=0 throughout. Pulse `reset_n` low mid-fill → outputs return to reset values; next "abc" message is correct.
- With `SHA1_PAD_BYTESWAP_EN`: "abc" as 0x00636261 → same block as the first scenario.
